// File: rtl/operand_stage_if.sv
// Bundle of every non-clock signal around the operand stage.
// The slave modport is the stage's view. The master modport is the view of
// the surrounding pipeline, register file and hazard control.
interface operand_stage_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
);
  // Decoded instruction fields from ID
  logic              id_valid;
  logic [AWIDTH-1:0] id_rs1;
  logic [AWIDTH-1:0] id_rs2;
  logic [AWIDTH-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_regw;
  logic              id_memread;
  logic [DWIDTH-1:0] id_imm;
  logic [DWIDTH-1:0] id_pc;
  logic [CWIDTH-1:0] id_ctrl;
  logic              id_ready;

  // Register-file read ports
  logic [AWIDTH-1:0] addrA;
  logic [AWIDTH-1:0] addrB;
  logic [DWIDTH-1:0] dataA;
  logic [DWIDTH-1:0] dataB;

  // Forwarding sources from the later stages
  logic              exm_regw;
  logic [AWIDTH-1:0] exm_rd;
  logic [DWIDTH-1:0] exm_result;
  logic              mwb_regw;
  logic [AWIDTH-1:0] mwb_rd;
  logic [DWIDTH-1:0] mwb_result;

  // Pipeline control
  logic              flush;
  logic              ex_stall;

  // EX-stage register outputs
  logic              ex_valid;
  logic [DWIDTH-1:0] ex_rs1_val;
  logic [DWIDTH-1:0] ex_rs2_val;
  logic [DWIDTH-1:0] ex_imm;
  logic [DWIDTH-1:0] ex_pc;
  logic [AWIDTH-1:0] ex_rd;
  logic              ex_regw;
  logic              ex_memread;
  logic [CWIDTH-1:0] ex_ctrl;
  logic [15:0]       stall_cnt;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    input  id_regw, id_memread, id_imm, id_pc, id_ctrl,
    output id_ready,
    output addrA, addrB,
    input  dataA, dataB,
    input  exm_regw, exm_rd, exm_result, mwb_regw, mwb_rd, mwb_result,
    input  flush, ex_stall,
    output ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_pc, ex_rd,
    output ex_regw, ex_memread, ex_ctrl, stall_cnt
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    output id_regw, id_memread, id_imm, id_pc, id_ctrl,
    input  id_ready,
    input  addrA, addrB,
    output dataA, dataB,
    output exm_regw, exm_rd, exm_result, mwb_regw, mwb_rd, mwb_result,
    output flush, ex_stall,
    input  ex_valid, ex_rs1_val, ex_rs2_val, ex_imm, ex_pc, ex_rd,
    input  ex_regw, ex_memread, ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_stage.sv
// Operand stage sitting between ID and EX.
// - Reads the register file combinationally.
// - Resolves forwarding from the EX/MEM and MEM/WB stages.
// - Detects load-use hazards and inserts bubbles for them.
// - Registers the selected operands into the EX pipeline register.
module operand_stage #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  operand_stage_if.slave   bus
);

  // ---------------------------------------------------------------------
  // EX pipeline register state
  // ---------------------------------------------------------------------
  logic              ex_valid_q,   ex_valid_d;
  logic              ex_regw_q,    ex_regw_d;
  logic              ex_memread_q, ex_memread_d;
  logic [DWIDTH-1:0] ex_rs1_val_q, ex_rs1_val_d;
  logic [DWIDTH-1:0] ex_rs2_val_q, ex_rs2_val_d;
  logic [DWIDTH-1:0] ex_imm_q,     ex_imm_d;
  logic [DWIDTH-1:0] ex_pc_q,      ex_pc_d;
  logic [AWIDTH-1:0] ex_rd_q,      ex_rd_d;
  logic [CWIDTH-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic [15:0]       stall_cnt_q,  stall_cnt_d;

  // ---------------------------------------------------------------------
  // Per-source operand inputs
  // ---------------------------------------------------------------------
  // Index 0 is rs1, which uses read port A.
  // Index 1 is rs2, which uses read port B.
  logic [AWIDTH-1:0] src_addr [2];
  logic [DWIDTH-1:0] src_rf   [2];
  logic              src_use  [2];

  assign src_addr[0] = bus.id_rs1;
  assign src_addr[1] = bus.id_rs2;
  assign src_rf[0]   = bus.dataA;
  assign src_rf[1]   = bus.dataB;
  assign src_use[0]  = bus.id_use_rs1;
  assign src_use[1]  = bus.id_use_rs2;

  // The read addresses come straight from decode.
  // The register file answers within the same cycle.
  assign bus.addrA = bus.id_rs1;
  assign bus.addrB = bus.id_rs2;

  // ---------------------------------------------------------------------
  // Forwarding muxes and load-use match, one copy per source operand
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [DWIDTH-1:0] val;
      logic              exm_hit;
      logic              mwb_hit;
      logic              load_hit;

      // A producer writing x0 never forwards.
      // This holds even if its regw bit is set.
      assign exm_hit = bus.exm_regw && (bus.exm_rd != '0) &&
                       (bus.exm_rd == src_addr[gi]);
      assign mwb_hit = bus.mwb_regw && (bus.mwb_rd != '0) &&
                       (bus.mwb_rd == src_addr[gi]);

      // Operand priority, highest first:
      // x0, then the youngest producer (EX/MEM), then MEM/WB,
      // then the register file.
      always_comb begin
        val = src_rf[gi];
        if (src_addr[gi] == '0) begin
          val = '0;
        end else if (exm_hit) begin
          val = bus.exm_result;
        end else if (mwb_hit) begin
          val = bus.mwb_result;
        end
      end

      // This operand is actually read, and it names the load now in EX.
      assign load_hit = src_use[gi] && (src_addr[gi] == ex_rd_q);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Load-use hazard and decode handshake
  // ---------------------------------------------------------------------
  logic hazard;

  // A load in EX has no data yet for a dependent instruction in ID.
  // That instruction must wait one cycle.
  assign hazard = bus.id_valid && ex_valid_q && ex_memread_q &&
                  (ex_rd_q != '0) &&
                  (g_src[0].load_hit || g_src[1].load_hit);

  assign bus.id_ready = !bus.ex_stall && !hazard;

  // ---------------------------------------------------------------------
  // Next-state selection for the EX pipeline register
  // ---------------------------------------------------------------------
  // The cases are checked in priority order: flush, stall, hazard, capture.
  // rst is handled in the register process.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_regw_d    = ex_regw_q;
    ex_memread_d = ex_memread_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_imm_d     = ex_imm_q;
    ex_pc_d      = ex_pc_q;
    ex_rd_d      = ex_rd_q;
    ex_ctrl_d    = ex_ctrl_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      // Squash.
      // Data fields are left as they are, since nothing consumes them.
      ex_valid_d   = 1'b0;
      ex_regw_d    = 1'b0;
      ex_memread_d = 1'b0;
    end else if (bus.ex_stall) begin
      // Downstream is busy, so everything holds (the defaults above).
      ex_valid_d   = ex_valid_q;
    end else if (hazard) begin
      // Insert a bubble and count it.
      // The counter saturates instead of wrapping.
      ex_valid_d   = 1'b0;
      ex_regw_d    = 1'b0;
      ex_memread_d = 1'b0;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      // Capture.
      // Forwarding is sampled now. An instruction that waited therefore
      // picks up whatever producer is current at this cycle.
      ex_valid_d   = bus.id_valid;
      ex_regw_d    = bus.id_regw & bus.id_valid;
      ex_memread_d = bus.id_memread & bus.id_valid;
      ex_rs1_val_d = g_src[0].val;
      ex_rs2_val_d = g_src[1].val;
      ex_imm_d     = bus.id_imm;
      ex_pc_d      = bus.id_pc;
      ex_rd_d      = bus.id_rd;
      ex_ctrl_d    = bus.id_ctrl;
    end
  end

  // ---------------------------------------------------------------------
  // EX pipeline register with synchronous reset
  // ---------------------------------------------------------------------
  // Reset takes priority over every other case.
  // It discards any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_regw_q    <= 1'b0;
      ex_memread_q <= 1'b0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_regw_q    <= ex_regw_d;
      ex_memread_q <= ex_memread_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_pc_q      <= ex_pc_d;
      ex_rd_q      <= ex_rd_d;
      ex_ctrl_q    <= ex_ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs come directly from flops
  // ---------------------------------------------------------------------
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_regw    = ex_regw_q;
  assign bus.ex_memread = ex_memread_q;
  assign bus.ex_rs1_val = ex_rs1_val_q;
  assign bus.ex_rs2_val = ex_rs2_val_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage.
// Covers capture, forwarding priority, x0 suppression, load-use bubbles,
// flush, stall, reset, and saturation of the stall counter.
module tb_operand_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  operand_stage_if bus ();

  operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register file.
  // It is addressed through the DUT's read addresses.
  logic [31:0] rf [32];
  assign bus.dataA = rf[bus.addrA];
  assign bus.dataB = rf[bus.addrB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic regw, input logic mr, input logic [31:0] pc);
    bus.id_valid   = v;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_regw    = regw;
    bus.id_memread = mr;
    bus.id_pc      = pc;
    bus.id_imm     = pc + 32'h1000;
    bus.id_ctrl    = pc[15:0] ^ 16'hA5A5;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[3] = 32'h33;
    rf[5] = 32'h11;
    bus.exm_regw = 1'b0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.mwb_regw = 1'b0; bus.mwb_rd = '0; bus.mwb_result = '0;
    bus.flush = 1'b0;
    bus.ex_stall = 1'b0;

    // Reset with a valid instruction presented. It must be discarded.
    rst = 1'b1;
    set_id(1'b1, 5'd5, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    tick(); tick();
    chk("rst_ex_valid",   {31'b0, bus.ex_valid},   32'h0);
    chk("rst_ex_regw",    {31'b0, bus.ex_regw},    32'h0);
    chk("rst_ex_memread", {31'b0, bus.ex_memread}, 32'h0);
    chk("rst_ex_pc",      bus.ex_pc,               32'h0);
    chk("rst_ex_imm",     bus.ex_imm,              32'h0);
    chk("rst_ex_ctrl",    {16'b0, bus.ex_ctrl},    32'h0);
    chk("rst_ex_rs1",     bus.ex_rs1_val,          32'h0);
    chk("rst_ex_rd",      {27'b0, bus.ex_rd},      32'h0);
    chk("rst_stall_cnt",  {16'b0, bus.stall_cnt},  32'h0);
    chk("rst_id_ready",   {31'b0, bus.id_ready},   32'h1);
    bus.ex_stall = 1'b1; #1;
    chk("rst_stall_id_ready", {31'b0, bus.id_ready}, 32'h0);
    bus.ex_stall = 1'b0;

    // No-hazard capture: add x9 = x5 + x0.
    rst = 1'b0;
    set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
    #1;
    chk("addrA", {27'b0, bus.addrA}, 32'd5);
    chk("addrB", {27'b0, bus.addrB}, 32'd0);
    tick();
    chk("cap_ex_valid", {31'b0, bus.ex_valid},   32'h1);
    chk("cap_rs1",      bus.ex_rs1_val,          32'h11);
    chk("cap_rs2",      bus.ex_rs2_val,          32'h0);
    chk("cap_rd",       {27'b0, bus.ex_rd},      32'd9);
    chk("cap_regw",     {31'b0, bus.ex_regw},    32'h1);
    chk("cap_memread",  {31'b0, bus.ex_memread}, 32'h0);
    chk("cap_pc",       bus.ex_pc,               32'h100);
    chk("cap_imm",      bus.ex_imm,              32'h1100);
    chk("cap_ctrl",     {16'b0, bus.ex_ctrl},    32'h0000A4A5);

    // Forward priority: EX/MEM first, then MEM/WB, then the register file.
    rf[5] = 32'hCC;
    bus.exm_regw = 1'b1; bus.exm_rd = 5'd5; bus.exm_result = 32'hAA;
    bus.mwb_regw = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_result = 32'hBB;
    set_id(1'b1, 5'd5, 5'd5, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104);
    tick();
    chk("fwd_exm_rs1", bus.ex_rs1_val, 32'hAA);
    chk("fwd_exm_rs2", bus.ex_rs2_val, 32'hAA);
    bus.exm_regw = 1'b0;
    tick();
    chk("fwd_mwb_rs1", bus.ex_rs1_val, 32'hBB);
    bus.mwb_regw = 1'b0;
    tick();
    chk("fwd_rf_rs1", bus.ex_rs1_val, 32'hCC);

    // Producers writing x0 must never forward.
    bus.exm_regw = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hDEAD;
    bus.mwb_regw = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_result = 32'hBEEF;
    set_id(1'b1, 5'd0, 5'd3, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h108);
    tick();
    chk("x0_rs1", bus.ex_rs1_val, 32'h0);
    chk("x0_rs2", bus.ex_rs2_val, 32'h33);
    bus.exm_regw = 1'b0; bus.mwb_regw = 1'b0;

    // An invalid ID slot captures as a bubble, and its regw/memread are masked.
    set_id(1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10C);
    tick();
    chk("inv_ex_valid",   {31'b0, bus.ex_valid},   32'h0);
    chk("inv_ex_regw",    {31'b0, bus.ex_regw},    32'h0);
    chk("inv_ex_memread", {31'b0, bus.ex_memread}, 32'h0);

    // Load-use: a load to x7 enters EX, then a consumer of x7 waits one cycle.
    set_id(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200);
    tick();
    chk("ld_ex_memread", {31'b0, bus.ex_memread}, 32'h1);
    chk("ld_ex_rd",      {27'b0, bus.ex_rd},      32'd7);
    set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h204);
    #1;
    chk("lu_id_ready", {31'b0, bus.id_ready}, 32'h0);
    tick();
    chk("lu_bubble_valid", {31'b0, bus.ex_valid},  32'h0);
    chk("lu_bubble_regw",  {31'b0, bus.ex_regw},   32'h0);
    chk("lu_stall_cnt",    {16'b0, bus.stall_cnt}, 32'd1);
    chk("lu_id_ready_after", {31'b0, bus.id_ready}, 32'h1);
    // The loaded value reaches MEM/WB.
    // It must be forwarded at the capture cycle.
    bus.mwb_regw = 1'b1; bus.mwb_rd = 5'd7; bus.mwb_result = 32'h7777;
    tick();
    chk("lu_cap_valid", {31'b0, bus.ex_valid},  32'h1);
    chk("lu_cap_rs1",   bus.ex_rs1_val,         32'h33);
    chk("lu_cap_rs2",   bus.ex_rs2_val,         32'h7777);
    chk("lu_cap_pc",    bus.ex_pc,              32'h204);
    chk("lu_cap_cnt",   {16'b0, bus.stall_cnt}, 32'd1);

    // Flush together with a hazard: flush wins and the counter does not move.
    set_id(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h208);
    tick();
    bus.mwb_regw = 1'b0;
    set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20C);
    bus.flush = 1'b1;
    tick();
    chk("fl_ex_valid",   {31'b0, bus.ex_valid},   32'h0);
    chk("fl_ex_regw",    {31'b0, bus.ex_regw},    32'h0);
    chk("fl_ex_memread", {31'b0, bus.ex_memread}, 32'h0);
    chk("fl_stall_cnt",  {16'b0, bus.stall_cnt},  32'd1);
    bus.flush = 1'b0;

    // Stall together with a hazard for 3 cycles: outputs hold and the counter does not move.
    set_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
    tick();
    chk("st_cap_pc", bus.ex_pc, 32'h300);
    bus.ex_stall = 1'b1;
    set_id(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h304);
    #1;
    chk("st_id_ready", {31'b0, bus.id_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_hold_valid", {31'b0, bus.ex_valid},   32'h1);
      chk("st_hold_pc",    bus.ex_pc,               32'h300);
      chk("st_hold_rs1",   bus.ex_rs1_val,          32'hCC);
      chk("st_hold_rd",    {27'b0, bus.ex_rd},      32'd7);
      chk("st_hold_mr",    {31'b0, bus.ex_memread}, 32'h1);
      chk("st_hold_cnt",   {16'b0, bus.stall_cnt},  32'd1);
    end

    // Reset during the stall clears everything.
    rst = 1'b1;
    tick();
    chk("strst_valid", {31'b0, bus.ex_valid},  32'h0);
    chk("strst_pc",    bus.ex_pc,              32'h0);
    chk("strst_rs1",   bus.ex_rs1_val,         32'h0);
    chk("strst_rd",    {27'b0, bus.ex_rd},     32'h0);
    chk("strst_cnt",   {16'b0, bus.stall_cnt}, 32'h0);
    chk("strst_id_ready", {31'b0, bus.id_ready}, 32'h0);

    // Saturation: preset the counter near its top, then produce 3 bubbles.
    // A load that reads its own rd bubbles on every other cycle.
    rst = 1'b0;
    bus.ex_stall = 1'b0;
    set_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    tick(); // capture
    tick(); // bubble
    chk("sat_bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("sat_cnt_fffe", {16'b0, bus.stall_cnt}, 32'h0000FFFE);
    tick(); tick();
    chk("sat_cnt_ffff", {16'b0, bus.stall_cnt}, 32'h0000FFFF);
    tick(); tick();
    chk("sat_cnt_hold", {16'b0, bus.stall_cnt}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
